// File: rtl/bsg_lru_pseudo_tree_state_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bsg_lru_pseudo_tree_state_if                                  |
// | Purpose  : Request/response bundle for the pseudo-LRU tree state store.  |
// |            Carries read and touch requests in, and the registered tree   |
// |            bits of the read set out.                                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface bsg_lru_pseudo_tree_state_if #(
  parameter int sets_p = 64,
  parameter int ways_p = 8
);

  localparam int c_lg_sets = (sets_p > 1) ? $clog2(sets_p) : 1;
  localparam int c_lg_ways = (ways_p > 1) ? $clog2(ways_p) : 1;
  localparam int c_tree_w  = (ways_p > 1) ? (ways_p - 1) : 1;

  // read request
  logic                 read_v_i;
  logic [c_lg_sets-1:0] read_set_i;

  // touch (hit or fill) request
  logic                 touch_v_i;
  logic [c_lg_sets-1:0] touch_set_i;
  logic [c_lg_ways-1:0] touch_way_i;

  // registered read response
  logic                 lru_v_o;
  logic [c_tree_w-1:0]  lru_o;

  // requester side
  modport master (
    output read_v_i,
    output read_set_i,
    output touch_v_i,
    output touch_set_i,
    output touch_way_i,
    input  lru_v_o,
    input  lru_o
  );

  // state-store side
  modport slave (
    input  read_v_i,
    input  read_set_i,
    input  touch_v_i,
    input  touch_set_i,
    input  touch_way_i,
    output lru_v_o,
    output lru_o
  );

endinterface
`default_nettype wire

// File: rtl/bsg_lru_pseudo_tree_state.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bsg_lru_pseudo_tree_state                                     |
// | Purpose  : Per-set pseudo-LRU tree bits (heap order, root at bit 0).     |
// |            A touch redirects every node on the touched way's root-to-    |
// |            leaf path away from that way. A read returns the set's tree   |
// |            one cycle later, including a same-cycle touch to that set.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bsg_lru_pseudo_tree_state #(
  parameter int sets_p = 64,
  parameter int ways_p = 8
) (
  input  wire logic                        clk_i,
  input  wire logic                        reset_i,
  bsg_lru_pseudo_tree_state_if.slave       bus
);

  localparam int c_lg_sets = (sets_p > 1) ? $clog2(sets_p) : 1;
  localparam int c_lg_ways = (ways_p > 1) ? $clog2(ways_p) : 1;
  localparam int c_tree_w  = (ways_p > 1) ? (ways_p - 1) : 1;

  // ---------------------------------------------------------------------
  // Storage: one tree per set
  // ---------------------------------------------------------------------
  logic [c_tree_w-1:0] tree_q [sets_p];

  // ---------------------------------------------------------------------
  // Path decode for the touched way.
  //   w_path_mask[n] : node n lies on the root-to-leaf path of touch_way_i
  //   w_path_val[n]  : value that points node n away from the touched way
  // Node n at level k, position j (n = 2^k - 1 + j) is on the path when
  // the top k bits of the way index equal j. The branch taken at level k
  // is way bit [lg-1-k]; the node is written with its inverse.
  // ---------------------------------------------------------------------
  logic [c_tree_w-1:0] w_path_mask;
  logic [c_tree_w-1:0] w_path_val;

  for (genvar k = 0; k < c_lg_ways; k++) begin : g_level
    for (genvar j = 0; j < (1 << k); j++) begin : g_node
      localparam int                   c_node = (1 << k) - 1 + j;
      localparam logic [c_lg_ways-1:0] c_pos  = c_lg_ways'(j);

      // top k way bits, right-aligned; zero at the root level
      logic [c_lg_ways-1:0] w_prefix;
      assign w_prefix = bus.touch_way_i >> (c_lg_ways - k);

      assign w_path_mask[c_node] = (w_prefix == c_pos);
      assign w_path_val[c_node]  = ~bus.touch_way_i[c_lg_ways-1-k];
    end
  end

  // ---------------------------------------------------------------------
  // New tree value of the touched set: path nodes replaced, others kept.
  // ---------------------------------------------------------------------
  logic [c_tree_w-1:0] w_touch_row_d;
  assign w_touch_row_d = (tree_q[bus.touch_set_i] & ~w_path_mask)
                       | (w_path_val              &  w_path_mask);

  // ---------------------------------------------------------------------
  // Read data with write-first bypass of a same-cycle touch to the set.
  // ---------------------------------------------------------------------
  logic                w_bypass;
  logic [c_tree_w-1:0] lru_d;

  assign w_bypass = bus.touch_v_i && (bus.touch_set_i == bus.read_set_i);

  // Select the stored row, or the freshly touched row when they collide.
  always_comb begin
    lru_d = tree_q[bus.read_set_i];
    if (w_bypass) begin
      lru_d = w_touch_row_d;
    end
  end

  // Tree storage: clear on reset, otherwise write the touched set's row.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int s = 0; s < sets_p; s++) begin
        tree_q[s] <= '0;
      end
    end else if (bus.touch_v_i) begin
      tree_q[bus.touch_set_i] <= w_touch_row_d;
    end
  end

  // ---------------------------------------------------------------------
  // Registered read response; data holds while no read is issued.
  // ---------------------------------------------------------------------
  logic                lru_v_q;
  logic [c_tree_w-1:0] lru_q;

  // Capture read valid every cycle, read data only on a read.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lru_v_q <= 1'b0;
      lru_q   <= '0;
    end else begin
      lru_v_q <= bus.read_v_i;
      if (bus.read_v_i) begin
        lru_q <= lru_d;
      end
    end
  end

  assign bus.lru_v_o = lru_v_q;
  assign bus.lru_o   = lru_q;

  // ---------------------------------------------------------------------
  // Illegal set indices can only arise when sets_p is not a power of two.
  // ---------------------------------------------------------------------
  if (sets_p != (1 << c_lg_sets)) begin : g_range_chk
    localparam logic [c_lg_sets:0] c_sets_lim = (c_lg_sets + 1)'(sets_p);

    // Flag any valid request that names a set beyond the array.
    always_ff @(posedge clk_i) begin
      if (!reset_i) begin
        if (bus.read_v_i) begin
          assert ({1'b0, bus.read_set_i} < c_sets_lim);
        end
        if (bus.touch_v_i) begin
          assert ({1'b0, bus.touch_set_i} < c_sets_lim);
        end
      end
    end
  end

endmodule
`default_nettype wire
